// File: rtl/mem_port_arbiter.sv
// N-channel request/grant arbiter onto a single cached-memory port, with per-port stall,
// registered response and timeout abort. Define ARB_ROUND_ROBIN_EN for round-robin grants.
module mem_port_arbiter #(
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [NUM_PORTS-1:0]               port_req,
  input  logic [NUM_PORTS-1:0]               port_we,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]    port_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]    port_wdata,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0]  port_mask,
  output logic [NUM_PORTS-1:0]               port_done,
  output logic [NUM_PORTS-1:0]               port_err,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]    port_rdata,
  output logic [NUM_PORTS-1:0]               port_stall,
  output logic                               mem_req,
  output logic                               mem_we,
  output logic [ADDR_WIDTH-1:0]              mem_addr,
  output logic [DATA_WIDTH-1:0]              mem_wdata,
  output logic [DATA_WIDTH/8-1:0]            mem_mask,
  input  logic                               mem_done,
  input  logic [DATA_WIDTH-1:0]              mem_rdata,
  output logic                               busy
);

  localparam int unsigned MW = DATA_WIDTH / 8;
  localparam int unsigned GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]                      state_q, state_d;
  logic [GW-1:0]                   grant_q, grant_d;
  logic                            mem_req_q, mem_req_d;
  logic                            mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0]           mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]           mem_wdata_q, mem_wdata_d;
  logic [MW-1:0]                   mem_mask_q, mem_mask_d;
  logic [CW-1:0]                   cnt_q, cnt_d;
  logic [NUM_PORTS-1:0]            done_q, done_d;
  logic [NUM_PORTS-1:0]            err_q, err_d;
  logic [NUM_PORTS*DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic          any_req;
  logic [GW-1:0] sel;

`ifdef ARB_ROUND_ROBIN_EN
  logic [GW-1:0] last_q, last_d;
  int unsigned   idx;

  // Search upward from the port after the last grant, wrapping at NUM_PORTS.
  always_comb begin
    any_req = 1'b0;
    sel     = '0;
    idx     = 0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      idx = (32'(last_q) + 1 + k) % NUM_PORTS;
      if (!any_req && port_req[idx[GW-1:0]]) begin
        any_req = 1'b1;
        sel     = idx[GW-1:0];
      end
    end
  end
`else
  always_comb begin
    any_req = 1'b0;
    sel     = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (port_req[i[GW-1:0]]) begin
        any_req = 1'b1;
        sel     = i[GW-1:0];
      end
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_mask_d  = mem_mask_q;
    cnt_d       = cnt_q;
    done_d      = '0;
    err_d       = '0;
    rdata_d     = rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_d      = last_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          state_d     = S_BUSY;
          grant_d     = sel;
          mem_req_d   = 1'b1;
          mem_we_d    = port_we[sel];
          mem_addr_d  = port_addr[sel*ADDR_WIDTH +: ADDR_WIDTH];
          mem_wdata_d = port_wdata[sel*DATA_WIDTH +: DATA_WIDTH];
          mem_mask_d  = port_mask[sel*MW +: MW];
          cnt_d       = '0;
`ifdef ARB_ROUND_ROBIN_EN
          last_d      = sel;
`endif
        end
      end
      S_BUSY: begin
        // mem_done is checked first so a completion on the last allowed cycle is not an error.
        if (mem_done) begin
          state_d          = S_RESP;
          mem_req_d        = 1'b0;
          done_d[grant_q]  = 1'b1;
          if (!mem_we_q) rdata_d[grant_q*DATA_WIDTH +: DATA_WIDTH] = mem_rdata;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          state_d         = S_RESP;
          mem_req_d       = 1'b0;
          done_d[grant_q] = 1'b1;
          err_d[grant_q]  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_mask_q  <= '0;
      cnt_q       <= '0;
      done_q      <= '0;
      err_q       <= '0;
      rdata_q     <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_q      <= GW'(NUM_PORTS - 1);
`endif
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_mask_q  <= mem_mask_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_q      <= last_d;
`endif
    end
  end

  assign port_done  = done_q;
  assign port_err   = err_q;
  assign port_rdata = rdata_q;
  assign port_stall = port_req & ~done_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_mask   = mem_mask_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: random requesters and memory latency against a
// transaction-level reference model (honours ARB_ROUND_ROBIN_EN when defined).
module tb_mem_port_arbiter;

  localparam int N  = 3;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int MW = DW / 8;
  localparam int TO = 8;
  localparam int NCYC = 3000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [N-1:0]      port_req, port_we;
  logic [N*AW-1:0]   port_addr;
  logic [N*DW-1:0]   port_wdata;
  logic [N*MW-1:0]   port_mask;
  logic [N-1:0]      port_done, port_err, port_stall;
  logic [N*DW-1:0]   port_rdata;
  logic              mem_req, mem_we, mem_done, busy;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata, mem_rdata;
  logic [MW-1:0]     mem_mask;

  mem_port_arbiter #(
    .NUM_PORTS (N),
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .TIMEOUT   (TO)
  ) dut (
    .clock     (clk),
    .reset     (rst),
    .port_req  (port_req),
    .port_we   (port_we),
    .port_addr (port_addr),
    .port_wdata(port_wdata),
    .port_mask (port_mask),
    .port_done (port_done),
    .port_err  (port_err),
    .port_rdata(port_rdata),
    .port_stall(port_stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_mask  (mem_mask),
    .mem_done  (mem_done),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  int n_vec = 0;
  int n_err = 0;

  // Requester side: each port's pending request.
  bit            r_req[N];
  bit            r_we[N];
  logic [AW-1:0] r_addr[N];
  logic [DW-1:0] r_wdata[N];
  logic [MW-1:0] r_mask[N];

  // Reference model: one transaction in service, or one response cycle.
  bit            m_active, m_resp, m_err, zero_chk;
  int            m_port, m_age, m_lat, m_last;
  bit            m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [MW-1:0] m_mask;
  logic [DW-1:0] m_rdata[N];

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic new_req(input int i);
    r_req[i]   = 1'b1;
    r_we[i]    = 1'($urandom % 2);
    r_addr[i]  = AW'($urandom);
    r_wdata[i] = $urandom;
    r_mask[i]  = MW'($urandom);
  endtask

  function automatic int pick(input logic [N-1:0] req, input int last);
`ifdef ARB_ROUND_ROBIN_EN
    for (int k = 1; k <= N; k++)
      if (req[(last + k) % N]) return (last + k) % N;
    return -1;
`else
    if (last < 0) return -1;
    for (int i = N - 1; i >= 0; i--)
      if (req[i]) return i;
    return -1;
`endif
  endfunction

  initial begin
    logic [N-1:0]    exp_done, exp_err;
    logic [N*DW-1:0] exp_rdata;
    int p;

    rst = 1'b1; port_req = '0; port_we = '0; port_addr = '0; port_wdata = '0; port_mask = '0;
    mem_done = 1'b0; mem_rdata = '0;
    m_active = 0; m_resp = 0; m_err = 0; zero_chk = 1; m_port = 0; m_age = 0; m_lat = 0;
    m_last = N - 1; m_we = 0; m_addr = '0; m_wdata = '0; m_mask = '0;
    for (int i = 0; i < N; i++) begin
      m_rdata[i] = '0; r_req[i] = 0; r_we[i] = 0; r_addr[i] = '0; r_wdata[i] = '0; r_mask[i] = '0;
    end

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      rst = (cyc < 2) || (cyc > 20 && m_active && ($urandom % 150 == 0));
      for (int i = 0; i < N; i++) begin
        if (r_req[i] && m_resp && m_port == i) begin
          if ($urandom % 2 == 0) new_req(i); else r_req[i] = 0;
        end else if (r_req[i]) begin
          if (m_active && m_port == i && ($urandom % 16 == 0)) r_req[i] = 0;
        end else if ($urandom % 3 == 0) begin
          new_req(i);
        end
        port_req[i]            = r_req[i];
        port_we[i]             = r_we[i];
        port_addr[i*AW +: AW]  = r_addr[i];
        port_wdata[i*DW +: DW] = r_wdata[i];
        port_mask[i*MW +: MW]  = r_mask[i];
      end
      mem_done  = m_active ? (m_age == m_lat) : ($urandom % 4 == 0);
      mem_rdata = $urandom;
      #1;

      exp_done = '0; exp_err = '0;
      if (m_resp) begin
        exp_done[m_port] = 1'b1;
        exp_err[m_port]  = m_err;
      end
      for (int i = 0; i < N; i++) exp_rdata[i*DW +: DW] = m_rdata[i];
      check_eq("busy",       busy,       m_active || m_resp);
      check_eq("mem_req",    mem_req,    m_active);
      check_eq("port_done",  port_done,  exp_done);
      check_eq("port_err",   port_err,   exp_err);
      check_eq("port_stall", port_stall, port_req & ~exp_done);
      check_eq("port_rdata", port_rdata, exp_rdata);
      if (m_active) begin
        check_eq("mem_we",    mem_we,    m_we);
        check_eq("mem_addr",  mem_addr,  m_addr);
        check_eq("mem_wdata", mem_wdata, m_wdata);
        check_eq("mem_mask",  mem_mask,  m_mask);
      end
      if (zero_chk) begin
        check_eq("rst_mem_we",    mem_we,    '0);
        check_eq("rst_mem_addr",  mem_addr,  '0);
        check_eq("rst_mem_wdata", mem_wdata, '0);
        check_eq("rst_mem_mask",  mem_mask,  '0);
      end

      @(posedge clk);
      zero_chk = 0;
      if (rst) begin
        m_active = 0; m_resp = 0; m_err = 0; m_last = N - 1; zero_chk = 1;
        for (int i = 0; i < N; i++) m_rdata[i] = '0;
      end else if (m_resp) begin
        m_resp = 0;
      end else if (m_active) begin
        if (mem_done) begin
          if (!m_we) m_rdata[m_port] = mem_rdata;
          m_active = 0; m_resp = 1; m_err = 0;
        end else if (m_age == TO - 1) begin
          m_active = 0; m_resp = 1; m_err = 1;
        end else begin
          m_age++;
        end
      end else begin
        p = pick(port_req, m_last);
        if (p >= 0) begin
          m_port = p; m_last = p; m_active = 1; m_age = 0;
          m_lat = int'($urandom_range(0, 11));
          m_we = r_we[p]; m_addr = r_addr[p]; m_wdata = r_wdata[p]; m_mask = r_mask[p];
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
